updown_counter_mod: RTL and testbench
=====================================

// Module: updown_counter_mod
// PURPOSE
//  Parametrised up/down counter with load, enable, programmable step and modulus limit,
//  selectable wrap or saturate behaviour, and terminal-event/overflow flags.
//  General-purpose timing/event counter for datapath and control blocks; drop-in superset
//  of the plain 64-bit up/down/load counter (STEP=1, LIMIT=all-ones, MODE=wrap).
// PARAMETERS
//  WIDTH   64  counter, data, step and limit width in bits (>=2)
//  MODE    0   0 = MODE_WRAP (modulo limit+1), 1 = MODE_SAT (clamp at 0 / limit)
// PORTS
//  clk      in   1      rising-edge clock
//  reset    in   1      asynchronous, active-high reset
//  en       in   1      count enable; no count change when low
//  load     in   1      synchronous load of data into count
//  up_down  in   1      1 = count up, 0 = count down
//  data     in   WIDTH  load value
//  step     in   WIDTH  increment/decrement magnitude per enabled cycle
//  limit    in   WIDTH  maximum count value; range is [0, limit]
//  ovf_clr  in   1      clears sticky ovf
//  count    out  WIDTH  registered count value
//  evt      out  1      registered 1-cycle pulse: last update wrapped or saturated
//  ovf      out  1      sticky: an event has occurred since last clear
//  zero     out  1      count == 0 (combinational from count)
//  at_limit out  1      count == limit (combinational from count, limit)
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert handled upstream): count=0, evt=0, ovf=0.
//    Reset mid-operation discards everything; no event is generated.
//  - Priority per rising edge: reset > load > en. load ignores en, step, limit.
//  - load: count<=data (stored as-is even if data>limit); evt<=0.
//  - en=0 and load=0: count holds, evt<=0.
//  - Up (en=1, up_down=1): s=count+step in WIDTH+1 bits.
//      s<=limit -> count<=s, evt<=0.
//      s>limit, MODE_WRAP -> count<=s-(limit+1); if that result >limit, count<=0; evt<=1.
//      s>limit, MODE_SAT  -> count<=limit; evt<=1.
//  - Down (en=1, up_down=0):
//      count>=step -> count<=count-step; if result>limit (count was above limit),
//        treat as event below; else evt<=0.
//      count<step, MODE_WRAP -> count<=count+(limit+1)-step (WIDTH+2-bit arith); if result
//        outside [0,limit], count<=limit; evt<=1.
//      count<step, MODE_SAT  -> count<=0; evt<=1.
//      Down from count>limit with count>=step and result>limit: count<=limit, evt<=1.
//  - step=0 with en=1: count holds, evt<=0 (no event even if count>limit).
//  - limit all-ones + MODE_WRAP + step=1: identical to natural 2^WIDTH wrap.
//  - limit changes take effect the same cycle; a current count above new limit is
//    corrected only on the next enabled count (rules above), never spontaneously.
//  - ovf: set on any cycle where evt is set; ovf_clr clears; set wins if both same edge.
//  - Latency: count/evt/ovf update one clock after inputs sampled; zero/at_limit follow
//    count (and limit) combinationally, no extra cycle.
// STRUCTURE
//  - Shared package/include: localparams MODE_WRAP=0, MODE_SAT=1; reused by sibling
//    timer/counter blocks.
//  - One sub-module: updown_counter_next (combinational: count, step, limit, up_down,
//    MODE -> next_count, event). Top holds count/evt/ovf registers and priority logic.
// TESTING (WIDTH=8 unless noted)
//  1 reset async mid-count (count=0x37, reset asserted between edges) -> count=0,evt=0,
//    ovf=0 immediately, before next clk edge.
//  2 WRAP, limit=9, step=3, up, from 0: counts 3,6,9,2(evt=1,ovf=1),5; then down from 1,
//    step=3 -> 8, evt=1.
//  3 SAT, limit=200, step=50, up from 180 -> 200 evt=1, holds 200 with evt=1 each cycle;
//    down step=50 from 30 -> 0 evt=1; at_limit/zero match.
//  4 load=1,en=1,up,data=0xF0,limit=0x10 -> count=0xF0,evt=0; next up step=1 WRAP -> 0,
//    evt=1; SAT -> 0x10, evt=1.
//  5 ovf_clr and event same edge -> ovf stays 1; ovf_clr alone next edge -> ovf=0;
//    step=0,en=1 -> count holds, evt=0.
//  6 WIDTH=64, limit=all-ones, WRAP, step=1: 0xFFFF_FFFF_FFFF_FFFF up -> 0,evt=1;
//    0 down -> all-ones, evt=1; random load/en/up_down vs reference model, 10k cycles.

Source files
------------

// File: rtl/updown_counter_mod_pkg.sv
// Shared constants for the counter/timer family: overflow handling modes.
package updown_counter_mod_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-count and event computation for one enabled counting step.
module updown_counter_next
  import updown_counter_mod_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int MODE  = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             up_down,
  output logic [WIDTH-1:0] next_count,
  output logic             evt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   lim1;
  logic [WIDTH:0]   wrap_up;
  logic [WIDTH-1:0] diff;
  logic [WIDTH+1:0] wrap_dn;

  // Extra bits keep the carry/borrow so comparisons against limit stay exact.
  assign sum     = {1'b0, count} + {1'b0, step};
  assign lim1    = {1'b0, limit} + {{WIDTH{1'b0}}, 1'b1};
  assign wrap_up = sum - lim1;
  assign diff    = count - step;
  assign wrap_dn = {2'b00, count} + {1'b0, lim1} - {2'b00, step};

  always_comb begin
    next_count = count;
    evt        = 1'b0;
    if (step != '0) begin
      if (up_down) begin
        if (sum <= {1'b0, limit}) begin
          next_count = sum[WIDTH-1:0];
        end else begin
          evt = 1'b1;
          if (MODE == MODE_SAT)
            next_count = limit;
          else if (wrap_up > {1'b0, limit})
            next_count = '0;
          else
            next_count = wrap_up[WIDTH-1:0];
        end
      end else begin
        if (count >= step) begin
          // A count left above a lowered limit is pulled back to limit here.
          if (diff > limit) begin
            next_count = limit;
            evt        = 1'b1;
          end else begin
            next_count = diff;
          end
        end else begin
          evt = 1'b1;
          if (MODE == MODE_SAT)
            next_count = '0;
          else if (wrap_dn > {2'b00, limit})
            next_count = limit;
          else
            next_count = wrap_dn[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter with load, programmable step and limit, wrap or saturate,
// and a registered event pulse plus sticky overflow flag.
module updown_counter_mod
  import updown_counter_mod_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int MODE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic             up_down,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             evt,
  output logic             ovf,
  output logic             zero,
  output logic             at_limit
);

  logic [WIDTH-1:0] next_count;
  logic             next_evt;
  logic             set_evt;

  updown_counter_next #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_next (
    .count      (count),
    .step       (step),
    .limit      (limit),
    .up_down    (up_down),
    .next_count (next_count),
    .evt        (next_evt)
  );

  assign set_evt = !load && en && next_evt;

  // Load outranks counting; an idle cycle only clears the event pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      evt   <= 1'b0;
    end else if (load) begin
      count <= data;
      evt   <= 1'b0;
    end else if (en) begin
      count <= next_count;
      evt   <= next_evt;
    end else begin
      evt   <= 1'b0;
    end
  end

  // A new event beats a simultaneous clear so no overflow is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovf <= 1'b0;
    else if (set_evt)
      ovf <= 1'b1;
    else if (ovf_clr)
      ovf <= 1'b0;
  end

  assign zero     = (count == '0);
  assign at_limit = (count == limit);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboarded bench: 8-bit wrap and saturate counters plus a 64-bit wrap counter.
module tb_updown_counter_mod;
  import updown_counter_mod_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        en, load, up_down, ovf_clr;
  logic [7:0]  data, step, limit;
  logic [7:0]  count_w, count_s;
  logic        evt_w, ovf_w, zero_w, at_limit_w;
  logic        evt_s, ovf_s, zero_s, at_limit_s;

  logic        en64, load64, up_down64, ovf_clr64;
  logic [63:0] data64, step64, limit64, count64;
  logic        evt64, ovf64, zero64, at_limit64;

  typedef struct {
    logic [65:0] cnt_w, cnt_s, cnt64;
    bit          evt_w, evt_s, evt64;
    bit          ovf_w, ovf_s, ovf64;
  } exp_t;

  exp_t        sb[$];
  logic [65:0] m_w, m_s, m_64;
  bit          mo_w, mo_s, mo_64;
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  t2_cnt [5];
  bit          t2_evt [5];

  updown_counter_mod #(.WIDTH(8), .MODE(MODE_WRAP)) dut_w (
    .clk(clk), .reset(reset), .en(en), .load(load), .up_down(up_down),
    .data(data), .step(step), .limit(limit), .ovf_clr(ovf_clr),
    .count(count_w), .evt(evt_w), .ovf(ovf_w), .zero(zero_w), .at_limit(at_limit_w));

  updown_counter_mod #(.WIDTH(8), .MODE(MODE_SAT)) dut_s (
    .clk(clk), .reset(reset), .en(en), .load(load), .up_down(up_down),
    .data(data), .step(step), .limit(limit), .ovf_clr(ovf_clr),
    .count(count_s), .evt(evt_s), .ovf(ovf_s), .zero(zero_s), .at_limit(at_limit_s));

  updown_counter_mod #(.WIDTH(64), .MODE(MODE_WRAP)) dut_64 (
    .clk(clk), .reset(reset), .en(en64), .load(load64), .up_down(up_down64),
    .data(data64), .step(step64), .limit(limit64), .ovf_clr(ovf_clr64),
    .count(count64), .evt(evt64), .ovf(ovf64), .zero(zero64), .at_limit(at_limit64));

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: exact arithmetic in 66 bits, negative wrap results checked explicitly.
  function automatic void refNext(input logic [65:0] c, st, lim, input bit up, sat,
                                  output logic [65:0] nc, output bit ev);
    nc = c;
    ev = 1'b0;
    if (st == 0) return;
    if (up) begin
      if (c + st <= lim) nc = c + st;
      else begin
        ev = 1'b1;
        if (sat) nc = lim;
        else begin
          nc = c + st - lim - 1;
          if (nc > lim) nc = 0;
        end
      end
    end else if (c >= st) begin
      if (c - st > lim) begin
        nc = lim;
        ev = 1'b1;
      end else nc = c - st;
    end else begin
      ev = 1'b1;
      if (sat) nc = 0;
      else if (st > c + lim + 1) nc = lim;
      else begin
        nc = c + lim + 1 - st;
        if (nc > lim) nc = lim;
      end
    end
  endfunction

  function automatic void modelStep(input logic [65:0] c, input bit o, ld, e, up, clr, sat,
                                    input logic [65:0] d, st, lim,
                                    output logic [65:0] nc, output bit ev, no);
    if (ld) begin
      nc = d;
      ev = 1'b0;
    end else if (e) refNext(c, st, lim, up, sat, nc, ev);
    else begin
      nc = c;
      ev = 1'b0;
    end
    no = ev ? 1'b1 : (clr ? 1'b0 : o);
  endfunction

  task automatic applyStimulus(input bit ld, e, up, clr, input logic [7:0] d, st, lim);
    load = ld; en = e; up_down = up; ovf_clr = clr; data = d; step = st; limit = lim;
  endtask

  task automatic applyStimulus64(input bit ld, e, up, clr, input logic [63:0] d, st, lim);
    load64 = ld; en64 = e; up_down64 = up; ovf_clr64 = clr; data64 = d; step64 = st; limit64 = lim;
  endtask

  task automatic runCycle();
    exp_t x;
    modelStep(m_w, mo_w, load, en, up_down, ovf_clr, 1'b0, 66'(data), 66'(step), 66'(limit),
              x.cnt_w, x.evt_w, x.ovf_w);
    modelStep(m_s, mo_s, load, en, up_down, ovf_clr, 1'b1, 66'(data), 66'(step), 66'(limit),
              x.cnt_s, x.evt_s, x.ovf_s);
    modelStep(m_64, mo_64, load64, en64, up_down64, ovf_clr64, 1'b0, 66'(data64), 66'(step64),
              66'(limit64), x.cnt64, x.evt64, x.ovf64);
    m_w = x.cnt_w; mo_w = x.ovf_w;
    m_s = x.cnt_s; mo_s = x.ovf_s;
    m_64 = x.cnt64; mo_64 = x.ovf64;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    checkOutput("w_cnt", 64'(count_w), x.cnt_w[63:0]);
    checkOutput("w_evt", 64'(evt_w), 64'(x.evt_w));
    checkOutput("w_ovf", 64'(ovf_w), 64'(x.ovf_w));
    checkOutput("w_zero", 64'(zero_w), 64'(x.cnt_w == 0));
    checkOutput("w_lim", 64'(at_limit_w), 64'(x.cnt_w == 66'(limit)));
    checkOutput("s_cnt", 64'(count_s), x.cnt_s[63:0]);
    checkOutput("s_evt", 64'(evt_s), 64'(x.evt_s));
    checkOutput("s_ovf", 64'(ovf_s), 64'(x.ovf_s));
    checkOutput("s_zero", 64'(zero_s), 64'(x.cnt_s == 0));
    checkOutput("s_lim", 64'(at_limit_s), 64'(x.cnt_s == 66'(limit)));
    checkOutput("c64_cnt", count64, x.cnt64[63:0]);
    checkOutput("c64_evt", 64'(evt64), 64'(x.evt64));
    checkOutput("c64_ovf", 64'(ovf64), 64'(x.ovf64));
    checkOutput("c64_zero", 64'(zero64), 64'(x.cnt64 == 0));
    checkOutput("c64_lim", 64'(at_limit64), 64'(x.cnt64 == 66'(limit64)));
  endtask

  initial begin
    t2_cnt = '{8'd3, 8'd6, 8'd9, 8'd2, 8'd5};
    t2_evt = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    m_w = 0; m_s = 0; m_64 = 0;
    mo_w = 0; mo_s = 0; mo_64 = 0;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 8'hFF);
    applyStimulus64(0, 0, 0, 0, 64'h0, 64'h1, '1);
    #12;
    checkOutput("rst_cnt", 64'(count_w), 64'h0);
    checkOutput("rst_evt", 64'(evt_w), 64'h0);
    checkOutput("rst_ovf", 64'(ovf_w), 64'h0);
    reset = 1'b0;
    runCycle();

    // Async reset from a mid-count state with ovf already set.
    applyStimulus(1, 0, 1, 0, 8'h37, 8'h00, 8'hFF); runCycle();
    applyStimulus(0, 1, 1, 0, 8'h00, 8'hFF, 8'hFF); runCycle();
    applyStimulus(1, 0, 1, 0, 8'h37, 8'h00, 8'hFF);
    applyStimulus64(1, 0, 1, 0, 64'h37, 64'h1, '1);
    runCycle();
    checkOutput("t1_pre", 64'(count_w), 64'h37);
    #2 reset = 1'b1;
    #1;
    checkOutput("t1_cnt_w", 64'(count_w), 64'h0);
    checkOutput("t1_ovf_w", 64'(ovf_w), 64'h0);
    checkOutput("t1_cnt_s", 64'(count_s), 64'h0);
    checkOutput("t1_ovf_s", 64'(ovf_s), 64'h0);
    checkOutput("t1_evt_s", 64'(evt_s), 64'h0);
    checkOutput("t1_cnt64", count64, 64'h0);
    m_w = 0; m_s = 0; m_64 = 0;
    mo_w = 0; mo_s = 0; mo_64 = 0;
    applyStimulus64(0, 0, 1, 0, 64'h0, 64'h1, '1);
    #1 reset = 1'b0;

    // Wrap sequence with limit 9, step 3.
    applyStimulus(1, 0, 1, 0, 8'd0, 8'd3, 8'd9); runCycle();
    applyStimulus(0, 1, 1, 0, 8'd0, 8'd3, 8'd9);
    for (int i = 0; i < 5; i++) begin
      runCycle();
      checkOutput("t2_cnt", 64'(count_w), 64'(t2_cnt[i]));
      checkOutput("t2_evt", 64'(evt_w), 64'(t2_evt[i]));
    end
    applyStimulus(1, 0, 0, 0, 8'd1, 8'd3, 8'd9); runCycle();
    applyStimulus(0, 1, 0, 0, 8'd0, 8'd3, 8'd9); runCycle();
    checkOutput("t2_dn_cnt", 64'(count_w), 64'd8);
    checkOutput("t2_dn_evt", 64'(evt_w), 64'd1);

    // Saturation at limit 200 and at zero.
    applyStimulus(1, 0, 1, 0, 8'd180, 8'd50, 8'd200); runCycle();
    applyStimulus(0, 1, 1, 0, 8'd0, 8'd50, 8'd200);
    for (int i = 0; i < 2; i++) begin
      runCycle();
      checkOutput("t3_up_cnt", 64'(count_s), 64'd200);
      checkOutput("t3_up_evt", 64'(evt_s), 64'd1);
      checkOutput("t3_atlim", 64'(at_limit_s), 64'd1);
    end
    applyStimulus(1, 0, 0, 0, 8'd30, 8'd50, 8'd200); runCycle();
    applyStimulus(0, 1, 0, 0, 8'd0, 8'd50, 8'd200); runCycle();
    checkOutput("t3_dn_cnt", 64'(count_s), 64'd0);
    checkOutput("t3_dn_evt", 64'(evt_s), 64'd1);
    checkOutput("t3_zero", 64'(zero_s), 64'd1);

    // Load above limit, then correction on the next count.
    applyStimulus(1, 1, 1, 0, 8'hF0, 8'h01, 8'h10); runCycle();
    checkOutput("t4_ld_cnt", 64'(count_w), 64'hF0);
    checkOutput("t4_ld_evt", 64'(evt_w), 64'h0);
    applyStimulus(0, 1, 1, 0, 8'h00, 8'h01, 8'h10); runCycle();
    checkOutput("t4_w_cnt", 64'(count_w), 64'h00);
    checkOutput("t4_w_evt", 64'(evt_w), 64'h1);
    checkOutput("t4_s_cnt", 64'(count_s), 64'h10);
    checkOutput("t4_s_evt", 64'(evt_s), 64'h1);

    // Sticky overflow clear versus a simultaneous event, and zero step.
    applyStimulus(0, 0, 1, 1, 8'h00, 8'h20, 8'h10); runCycle();
    checkOutput("t5_clr", 64'(ovf_w), 64'h0);
    applyStimulus(0, 1, 1, 1, 8'h00, 8'h20, 8'h10); runCycle();
    checkOutput("t5_set_w", 64'(ovf_w), 64'h1);
    checkOutput("t5_set_s", 64'(ovf_s), 64'h1);
    applyStimulus(0, 0, 1, 1, 8'h00, 8'h20, 8'h10); runCycle();
    checkOutput("t5_clr2", 64'(ovf_s), 64'h0);
    applyStimulus(1, 0, 1, 0, 8'h50, 8'h00, 8'h10); runCycle();
    applyStimulus(0, 1, 1, 0, 8'h00, 8'h00, 8'h10); runCycle();
    checkOutput("t5_st0_cnt", 64'(count_w), 64'h50);
    checkOutput("t5_st0_evt", 64'(evt_w), 64'h0);

    // 64-bit natural wrap in both directions.
    applyStimulus(0, 0, 1, 0, 8'h00, 8'h01, 8'hFF);
    applyStimulus64(1, 0, 1, 0, '1, 64'h1, '1); runCycle();
    applyStimulus64(0, 1, 1, 0, 64'h0, 64'h1, '1); runCycle();
    checkOutput("t6_up_cnt", count64, 64'h0);
    checkOutput("t6_up_evt", 64'(evt64), 64'h1);
    applyStimulus64(0, 1, 0, 0, 64'h0, 64'h1, '1); runCycle();
    checkOutput("t6_dn_cnt", count64, '1);
    checkOutput("t6_dn_evt", 64'(evt64), 64'h1);

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      logic [7:0]  lim8, st8;
      logic [63:0] d64;
      lim8 = limit;
      if (i % 50 == 0) lim8 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      st8 = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                    $urandom_range(0, 15) == 0, 8'($urandom), st8, lim8);
      case ($urandom_range(0, 3))
        0: d64 = '1;
        1: d64 = 64'h0;
        2: d64 = 64'hFFFF_FFFF_FFFF_FFFE;
        default: d64 = {$urandom, $urandom};
      endcase
      applyStimulus64($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                      $urandom_range(0, 15) == 0, d64, 64'h1, '1);
      runCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
